// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner for a packed 10-digit BCD word.
// New words are applied only at frame boundaries so a scan never mixes two values.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [39:0]           bcd_in,
  input  logic                  bcd_valid,
  input  logic                  blank_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  overflow,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [39:0]           pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [39:0]           disp_q, disp_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  ovf_q, ovf_d;
  logic                  fdone_q;

  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] zabove;
  logic                  zacc;
  logic [3:0]            cur;
  logic                  cur_z;
  logic                  cur_dp;
  logic                  blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  always_comb begin
    tick     = (presc_q == PMAX);
    boundary = tick && (idx_q == IMAX);
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IMAX) ? '0 : idx_q + IW'(1);
    end
  end

  // A strobe on the boundary cycle bypasses pending straight to display.
  always_comb begin
    pend_d  = pend_q;
    pflag_d = pflag_q;
    disp_d  = disp_q;
    if (bcd_valid) begin
      pend_d  = bcd_in;
      pflag_d = 1'b1;
    end
    if (boundary) begin
      if (bcd_valid) begin
        disp_d  = bcd_in;
        pflag_d = 1'b0;
      end else if (pflag_q) begin
        disp_d  = pend_q;
        pflag_d = 1'b0;
      end
    end
  end

  always_comb begin
    ovf_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k >= NUM_DIGITS) begin
        ovf_d = ovf_d | (|disp_q[4*k +: 4]);
      end
    end
  end

  // zabove[i]: digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zacc   = 1'b1;
    zabove = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc      = zacc & (disp_q[4*i +: 4] == 4'd0);
      zabove[i] = zacc;
    end
  end

  always_comb begin
    cur    = '0;
    cur_z  = 1'b0;
    cur_dp = 1'b0;
    an_d   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur     = disp_q[4*k +: 4];
        cur_z   = zabove[k];
        cur_dp  = dp_mask[k];
        an_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    blank = blank_en && (idx_q != '0) && cur_z && !ovf_d;
    if (ovf_d) begin
      seg_d = 7'h3F;
    end else if (blank) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = seg7(cur);
    end
    dp_d = blank ? 1'b1 : ~cur_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      disp_q  <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      ovf_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      ovf_q   <= ovf_d;
      fdone_q <= boundary;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign overflow   = ovf_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=8, REFRESH_DIV=4.
// Frames are 32 cycles; each digit slot is 4 cycles.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [39:0] bcd_in;
  logic        bcd_valid;
  logic        blank_en;
  logic [7:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        overflow;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] es [8];
  logic [7:0] edp;
  logic       eovf;

  bcd_display_scanner #(
    .NUM_DIGITS (8),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .blank_en  (blank_en),
    .dp_mask   (dp_mask),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .overflow  (overflow),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [39:0] got,
                     input logic [39:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse(input logic [39:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  task automatic sync_fd();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("sync_timeout", 40'(n < 100), 40'd1);
  endtask

  task automatic check_frame(input string nm);
    logic [7:0] ean;
    for (int d = 0; d < 8; d++) begin
      ean = ~(8'b1 << d);
      step();
      chk($sformatf("%s_an%0d", nm, d), 40'(an_n), 40'(ean));
      chk($sformatf("%s_seg%0d", nm, d), 40'(seg_n), 40'(es[d]));
      chk($sformatf("%s_dp%0d", nm, d), 40'(dp_n), 40'(edp[d]));
      chk($sformatf("%s_ovf%0d", nm, d), 40'(overflow), 40'(eovf));
      step();
      step();
      chk($sformatf("%s_anhold%0d", nm, d), 40'(an_n), 40'(ean));
      chk($sformatf("%s_fdlow%0d", nm, d), 40'(frame_done), 40'd0);
      step();
    end
    chk($sformatf("%s_fdend", nm), 40'(frame_done), 40'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bcd_in    = '0;
    bcd_valid = 1'b0;
    blank_en  = 1'b1;
    dp_mask   = 8'h00;
    repeat (10) @(negedge clk);
    chk("rst_seg", 40'(seg_n), 40'h7F);
    chk("rst_an", 40'(an_n), 40'hFF);
    chk("rst_dp", 40'(dp_n), 40'd1);
    chk("rst_fd", 40'(frame_done), 40'd0);
    chk("rst_ovf", 40'(overflow), 40'd0);

    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk("rel_an", 40'(an_n), 40'hFE);
    chk("rel_seg", 40'(seg_n), 40'h40);
    chk("rel_dp", 40'(dp_n), 40'd1);

    pulse(40'h00_0000_1234);
    sync_fd();
    chk("first_frame_len", 40'(cyc), 40'd32);
    es   = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    edp  = 8'hFF;
    eovf = 1'b0;
    check_frame("f1234");

    pulse(40'h0);
    sync_fd();
    es = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("fzero_bl");
    blank_en = 1'b0;
    es = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    check_frame("fzero_nobl");

    blank_en = 1'b1;
    pulse(40'h01_0000_0000);
    sync_fd();
    es   = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    eovf = 1'b1;
    check_frame("fovf");
    pulse(40'h00_0000_0005);
    sync_fd();
    es   = '{7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    eovf = 1'b0;
    check_frame("f5");

    pulse(40'h00_0000_1111);
    step();
    step();
    pulse(40'h00_0000_2222);
    sync_fd();
    es = '{7'h24, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("f2222");

    repeat (31) step();
    bcd_in    = 40'h00_0000_3333;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
    chk("coinc_fd", 40'(frame_done), 40'd1);
    es = '{7'h30, 7'h30, 7'h30, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    check_frame("f3333");

    dp_mask = 8'h14;
    pulse(40'h00_0000_0A00);
    sync_fd();
    es  = '{7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    edp = 8'b1111_1011;
    check_frame("fA00");

    dp_mask = 8'h00;
    pulse(40'h00_0000_0777);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_seg", 40'(seg_n), 40'h7F);
    chk("mrst_an", 40'(an_n), 40'hFF);
    chk("mrst_dp", 40'(dp_n), 40'd1);
    chk("mrst_fd", 40'(frame_done), 40'd0);
    chk("mrst_ovf", 40'(overflow), 40'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk("rel2_an", 40'(an_n), 40'hFE);
    chk("rel2_seg", 40'(seg_n), 40'h40);
    sync_fd();
    chk("rel2_frame_len", 40'(cyc), 40'd32);
    es  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    edp = 8'hFF;
    check_frame("fpostrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
